// File: rtl/wlan_mul_arbiter.sv
// Round-robin arbiter that shares one pipelined signed 32x32 multiplier among N_REQ requesters.
// Results leave in acceptance order, tagged with the owning requester index.
module wlan_mul_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MUL_STAGES = 2,
    parameter int DOUT_WIDTH = 54,
    localparam int IDW       = $clog2(N_REQ)
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [32*N_REQ-1:0]     req_din0,
    input  logic [32*N_REQ-1:0]     req_din1,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [IDW-1:0]          res_id,
    output logic [DOUT_WIDTH-1:0]   res_data,
    output logic                    busy
);

    logic                   stall;
    logic                   found;
    logic                   accept;
    logic [IDW-1:0]         grant_idx;
    logic [IDW-1:0]         last_grant_q, last_grant_d;
    logic [31:0]            sel_a, sel_b;
    logic [31:0]            a_q, a_d, b_q, b_d;
    logic [MUL_STAGES-1:0]  vld_q, vld_d;
    logic [IDW-1:0]         id_q [MUL_STAGES];
    logic [IDW-1:0]         id_d [MUL_STAGES];
    logic signed [DOUT_WIDTH-1:0] a_x, b_x, prod1;

    assign res_valid = vld_q[MUL_STAGES-1];
    assign res_id    = id_q[MUL_STAGES-1];
    assign busy      = |vld_q;
    assign stall     = res_valid & ~res_ready;
    assign accept    = found & ~stall;

    // Search starts one past the last winner and wraps.
    always_comb begin : arb
        int idx;
        idx       = 0;
        found     = 1'b0;
        grant_idx = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_grant_q) + i) % N_REQ;
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = IDW'(idx);
                sel_a     = req_din0[32*idx +: 32];
                sel_b     = req_din1[32*idx +: 32];
            end
        end
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin : pipe
        last_grant_d = last_grant_q;
        vld_d        = vld_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        if (!stall) begin
            vld_d[0] = accept;
            if (accept) begin
                id_d[0]      = grant_idx;
                a_d          = sel_a;
                b_d          = sel_b;
                last_grant_d = grant_idx;
            end
            for (int k = 1; k < MUL_STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                id_d[k]  = id_q[k-1];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            last_grant_q <= IDW'(N_REQ - 1);
            vld_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            for (int k = 0; k < MUL_STAGES; k++) begin
                id_q[k] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            vld_q        <= vld_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
        end
    end

    // Low DOUT_WIDTH bits of a two's-complement product only need DOUT_WIDTH-wide operands.
    assign a_x   = DOUT_WIDTH'($signed(a_q));
    assign b_x   = DOUT_WIDTH'($signed(b_q));
    assign prod1 = a_x * b_x;

    generate
        if (MUL_STAGES == 1) begin : g_direct
            assign res_data = prod1;
        end else begin : g_pipe
            logic [DOUT_WIDTH-1:0] data_q [MUL_STAGES-1];
            logic [DOUT_WIDTH-1:0] data_d [MUL_STAGES-1];

            always_comb begin
                data_d = data_q;
                if (!stall) begin
                    data_d[0] = prod1;
                    for (int k = 1; k < MUL_STAGES - 1; k++) begin
                        data_d[k] = data_q[k-1];
                    end
                end
            end

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    for (int k = 0; k < MUL_STAGES - 1; k++) begin
                        data_q[k] <= '0;
                    end
                end else begin
                    data_q <= data_d;
                end
            end

            assign res_data = data_q[MUL_STAGES-2];
        end
    endgenerate

endmodule

// File: doc/wlan_mul_arbiter.md
WLAN_MUL_ARBITER -- requirements
Module: wlan_mul_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters sharing the multiplier (2..8).
REQ-002 SHALL have parameter MUL_STAGES, default 2, meaning number of multiplier pipeline registers (1..4).
REQ-003 SHALL have parameter DOUT_WIDTH, default 54, meaning result width.
REQ-004 SHALL have port ap_clk  input  1  the single clock; all logic rising-edge triggered.
REQ-005 SHALL have port ap_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester operand-valid.
REQ-007 SHALL have port req_ready  output  N_REQ  per-requester accept, at most one bit high.
REQ-008 SHALL have port req_din0  input  32*N_REQ  signed operand A, requester i at bits [32i+31:32i].
REQ-009 SHALL have port req_din1  input  32*N_REQ  signed operand B, same packing.
REQ-010 SHALL have port res_valid  output  1  result valid.
REQ-011 SHALL have port res_ready  input  1  downstream accepts result.
REQ-012 SHALL have port res_id  output  clog2(N_REQ)  index of the requester that owns res_data.
REQ-013 SHALL have port res_data  output  DOUT_WIDTH  signed product.
REQ-014 SHALL have port busy  output  1  high when any pipeline stage holds a valid operation.

Function
REQ-015 SHALL compute res_data as the low DOUT_WIDTH bits of the full 64-bit two's-complement product din0*din1.
REQ-016 SHALL define stall = res_valid AND NOT res_ready; while stall is high, no stage advances and no request is accepted.
REQ-017 SHALL drive req_ready combinationally: when not stalled and at least one req_valid is high, assert exactly one bit, for the granted requester.
REQ-018 SHALL grant round-robin: search starts at (last_grant+1) mod N_REQ and ascends with wrap; the first requester with req_valid high wins.
REQ-019 SHALL update last_grant only on an accepted transfer (req_valid[i] AND req_ready[i]).
REQ-020 SHALL capture the operands and requester index into stage 1 on acceptance.
REQ-021 SHALL insert a bubble (stage valid = 0) when no request is accepted in a non-stalled cycle.
REQ-022 SHALL present a request accepted at edge t on res_valid/res_id/res_data after edge t+MUL_STAGES-1, provided no stall occurs; each stall cycle adds one cycle.
REQ-023 SHALL sustain one accepted request per cycle when res_ready is held high.
REQ-024 SHALL hold res_valid, res_id and res_data stable while stall is high.
REQ-025 SHALL never drop, duplicate or reorder operations; results leave in acceptance order.
REQ-026 SHALL continue to grant and accept a request in the same cycle that res_valid and res_ready are both high.
REQ-027 SHALL keep req_ready low for requesters with req_valid low; a requester that drops req_valid before acceptance is not served.
REQ-028 SHALL treat a single active requester as granted every non-stalled cycle (back-to-back).
REQ-029 SHALL drive busy as the OR of all stage valid bits, including the output stage.

Reset
REQ-030 SHALL, while ap_rst_n is low, clear all stage valid bits, set last_grant to N_REQ-1 (requester 0 highest priority), and zero all data and ID registers.
REQ-031 SHALL hold outputs after reset at res_valid=0, res_id=0, res_data=0 and busy=0, with req_ready following REQ-017.
REQ-032 SHALL discard all in-flight operations on reset assertion mid-operation, without producing any result for them after release.
REQ-033 SHALL accept a request in the first cycle after ap_rst_n deasserts.

Verification
REQ-034 SHALL be tested with a single op: requester 2 sends din0=-3, din1=7, res_ready=1 -> res_valid after MUL_STAGES cycles, res_id=2, res_data=-21 (54-bit sign-extended), then busy=0.
REQ-035 SHALL be tested with round-robin: all four req_valid held high, res_ready=1 -> grant sequence 0,1,2,3,0,1; res_id follows the same order.
REQ-036 SHALL be tested with a stall: res_ready=0 while a result is valid for 5 cycles -> res_* held constant, req_ready=0, no new accept; after release, the pipeline drains in order with no loss.
REQ-037 SHALL be tested with the width/edge case: din0=din1=0x80000000 -> res_data = low 54 bits of 2^62 = 0; din0=0x7FFFFFFF, din1=2 -> res_data=0x000FFFFFFFE.
REQ-038 SHALL be tested with reset mid-operation: assert ap_rst_n=0 with MUL_STAGES ops in flight -> res_valid=0 and busy=0 immediately; no stale result after release; the first grant goes to requester 0.
REQ-039 SHALL be tested with random traffic: random req_valid/res_ready patterns over 10k cycles, checked against a scoreboard for product value, id and ordering.
